// File: rtl/ring_source_module.sv
// Initiator end of the display ring: serial bus master, serial bus slave and the round FSM.
// Define RING_CHECK_EN to build the return-value comparator and the sticky mismatch flag.

// Frame: bus_util high for ADDRS_WIDTH+DATA_WIDTH clocks, b_RW held, address then data MSB first.
module ring_bus_master #(
    parameter int ADDRS_WIDTH = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_LEN = 6,
    parameter int BIT_LENGTH  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   m_hold,
    input  logic                   m_execute,
    input  logic                   m_RW,
    input  logic [ADDRS_WIDTH-1:0] m_address,
    input  logic [DATA_WIDTH-1:0]  m_din,
    input  logic                   b_grant,
    output logic                   b_request,
    output logic                   m_master_bsy,
    output logic                   m_dvalid,
    output logic [3:0]             mst_state,
    inout  wire                    bus_util,
    inout  wire                    data_bus_serial,
    inout  wire                    b_RW
);
    typedef enum logic [3:0] {M_IDLE = 4'd0, M_REQ = 4'd1, M_ADDR = 4'd2, M_DATA = 4'd3, M_DONE = 4'd4} mst_state_e;

    localparam logic [BIT_LENGTH-1:0] ADDR_LAST = BIT_LENGTH'(ADDRS_WIDTH - 1);
    localparam logic [BIT_LENGTH-1:0] DATA_LAST = BIT_LENGTH'(DATA_WIDTH - 1);

    mst_state_e             state_q, state_d;
    logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   rw_q, rw_d;
    logic [BIT_LENGTH-1:0]  bit_q, bit_d;
    logic [TIMEOUT_LEN-1:0] to_q, to_d;
    logic                   drive, drive_data;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = rw_q;
        bit_d   = bit_q;
        to_d    = to_q;
        case (state_q)
            M_IDLE: if (m_execute) begin
                addr_d  = m_address;
                data_d  = m_din;
                rw_d    = m_RW;
                to_d    = '0;
                state_d = M_REQ;
            end
            M_REQ: begin
                if (b_grant) begin
                    bit_d   = '0;
                    state_d = M_ADDR;
                end else if (&to_q) begin
                    state_d = M_IDLE;
                end else begin
                    to_d = to_q + TIMEOUT_LEN'(1);
                end
            end
            M_ADDR: begin
                addr_d = addr_q << 1;
                bit_d  = bit_q + BIT_LENGTH'(1);
                if (bit_q == ADDR_LAST) begin
                    bit_d   = '0;
                    state_d = M_DATA;
                end
            end
            M_DATA: begin
                data_d = data_q << 1;
                bit_d  = bit_q + BIT_LENGTH'(1);
                if (bit_q == DATA_LAST) state_d = M_DONE;
            end
            default: state_d = M_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= M_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            bit_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            bit_q   <= bit_d;
            to_q    <= to_d;
        end
    end

    // During a read the addressed slave owns the data line for the data phase.
    assign drive      = (state_q == M_ADDR) || (state_q == M_DATA);
    assign drive_data = (state_q == M_ADDR) || ((state_q == M_DATA) && rw_q);

    assign bus_util        = drive ? 1'b1 : 1'bz;
    assign b_RW            = drive ? rw_q : 1'bz;
    assign data_bus_serial = drive_data ? ((state_q == M_ADDR) ? addr_q[ADDRS_WIDTH-1] : data_q[DATA_WIDTH-1]) : 1'bz;

    assign b_request    = m_hold || (state_q == M_REQ);
    assign m_master_bsy = (state_q != M_IDLE);
    assign m_dvalid     = (state_q == M_DONE);
    assign mst_state    = state_q;
endmodule

module ring_bus_slave #(
    parameter int         ADDRS_WIDTH = 15,
    parameter int         DATA_WIDTH  = 8,
    parameter int         BIT_LENGTH  = 4,
    parameter logic [2:0] SELF_ID     = 3'd2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arbiter_cmd_in,
    input  logic [DATA_WIDTH-1:0] data_in_parellel,
    output logic [DATA_WIDTH-1:0] data_out_parellel,
    output logic                  write_en_internal,
    output logic                  busy_out,
    output logic [3:0]            slv_state,
    inout  wire                   bus_util,
    inout  wire                   data_bus_serial,
    inout  wire                   b_RW
);
    typedef enum logic [3:0] {S_IDLE = 4'd0, S_ADDR = 4'd1, S_WDATA = 4'd2, S_RDATA = 4'd3, S_SKIP = 4'd4} slv_state_e;

    localparam logic [BIT_LENGTH-1:0] ADDR_LAST = BIT_LENGTH'(ADDRS_WIDTH - 1);
    localparam logic [BIT_LENGTH-1:0] DATA_LAST = BIT_LENGTH'(DATA_WIDTH - 1);

    slv_state_e             state_q, state_d;
    logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d, dout_q, dout_d;
    logic [BIT_LENGTH-1:0]  bit_q, bit_d;
    logic                   wen_q, wen_d, req_q, req_d, dv_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        dout_d  = dout_q;
        bit_d   = bit_q + BIT_LENGTH'(1);
        wen_d   = 1'b0;
        req_d   = 1'b0;
        case (state_q)
            S_IDLE: if (bus_util && arbiter_cmd_in) begin
                addr_d  = {addr_q[ADDRS_WIDTH-2:0], data_bus_serial};
                bit_d   = BIT_LENGTH'(1);
                state_d = S_ADDR;
            end
            S_ADDR: begin
                addr_d = {addr_q[ADDRS_WIDTH-2:0], data_bus_serial};
                if (!bus_util) begin
                    state_d = S_IDLE;
                end else if (bit_q == ADDR_LAST) begin
                    bit_d = '0;
                    if (addr_d[ADDRS_WIDTH-1 -: 3] != SELF_ID) begin
                        state_d = S_SKIP;
                    end else if (b_RW) begin
                        state_d = S_WDATA;
                    end else begin
                        req_d   = 1'b1;
                        rdata_d = data_in_parellel;
                        state_d = S_RDATA;
                    end
                end
            end
            S_WDATA: begin
                wdata_d = {wdata_q[DATA_WIDTH-2:0], data_bus_serial};
                if (!bus_util) begin
                    state_d = S_IDLE;
                end else if (bit_q == DATA_LAST) begin
                    dout_d  = wdata_d;
                    wen_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                rdata_d = rdata_q << 1;
                if (!bus_util || bit_q == DATA_LAST) state_d = S_IDLE;
            end
            default: if (!bus_util) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
            bit_q   <= '0;
            wen_q   <= 1'b0;
            req_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            bit_q   <= bit_d;
            wen_q   <= wen_d;
            req_q   <= req_d;
            dv_q    <= req_q || wen_q;
        end
    end

    assign data_bus_serial   = (state_q == S_RDATA) ? rdata_q[DATA_WIDTH-1] : 1'bz;
    assign data_out_parellel = dout_q;
    assign write_en_internal = wen_q;
    assign busy_out          = (state_q != S_IDLE) || dv_q;
    assign slv_state         = state_q;
endmodule

module ring_source_module #(
    parameter int                     DATA_WIDTH  = 8,
    parameter int                     ADDRS_WIDTH = 15,
    parameter int                     TIMEOUT_LEN = 6,
    parameter int                     BIT_LENGTH  = 4,
    parameter logic [2:0]             SELF_ID     = 3'd2,
    parameter logic [ADDRS_WIDTH-1:0] DEST_ADDR   = {3'd0, 12'b0},
    parameter int                     RET_TO_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  b_grant,
    input  logic                  arbiter_cmd_in,
    inout  wire                   bus_util,
    inout  wire                   data_bus_serial,
    inout  wire                   b_RW,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [7:0]            n_rounds,
    output logic                  b_request,
    output logic                  m_master_bsy,
    output logic                  busy_out,
    output logic [3:0]            mst_state,
    output logic [3:0]            slv_state,
    output logic [DATA_WIDTH-1:0] tx_value,
    output logic [DATA_WIDTH-1:0] rx_value,
    output logic [7:0]            round_cnt,
    output logic                  running,
    output logic                  done,
    output logic                  mismatch,
    output logic                  timeout
);
    typedef enum logic [2:0] {IDLE, ARM, SEND, WAIT_ACK, WAIT_RET, CHECK} ring_state_e;

    ring_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d, rx_q, rx_d, data_out_parellel;
    logic [7:0]              round_q, round_d, round_inc;
    logic [RET_TO_LEN-1:0]   ret_q, ret_d;
    logic hold_q, hold_d, exec_q, exec_d, done_q, done_d;
    logic mismatch_q, mismatch_d, timeout_q, timeout_d;
    logic m_dvalid, write_en_internal;

    ring_bus_master #(.ADDRS_WIDTH(ADDRS_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                      .TIMEOUT_LEN(TIMEOUT_LEN), .BIT_LENGTH(BIT_LENGTH)) u_master (
        .clk(clk), .rstn(rstn), .m_hold(hold_q), .m_execute(exec_q), .m_RW(1'b1),
        .m_address(DEST_ADDR), .m_din(tx_q), .b_grant(b_grant), .b_request(b_request),
        .m_master_bsy(m_master_bsy), .m_dvalid(m_dvalid), .mst_state(mst_state),
        .bus_util(bus_util), .data_bus_serial(data_bus_serial), .b_RW(b_RW)
    );

    ring_bus_slave #(.ADDRS_WIDTH(ADDRS_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                     .BIT_LENGTH(BIT_LENGTH), .SELF_ID(SELF_ID)) u_slave (
        .clk(clk), .rstn(rstn), .arbiter_cmd_in(arbiter_cmd_in), .data_in_parellel(rx_q),
        .data_out_parellel(data_out_parellel), .write_en_internal(write_en_internal),
        .busy_out(busy_out), .slv_state(slv_state),
        .bus_util(bus_util), .data_bus_serial(data_bus_serial), .b_RW(b_RW)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        round_d    = round_q;
        ret_d      = ret_q;
        hold_d     = hold_q;
        exec_d     = 1'b0;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        timeout_d  = timeout_q;
        round_inc  = round_q + 8'd1;
        // Stop outranks everything, including a write-back landing in the same cycle.
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    hold_d = 1'b0;
                    if (write_en_internal) rx_d = data_out_parellel;
                    if (start) begin
                        tx_d       = seed;
                        round_d    = '0;
                        mismatch_d = 1'b0;
                        timeout_d  = 1'b0;
                        state_d    = ARM;
                    end
                end
                ARM: begin
                    hold_d  = 1'b1;
                    state_d = SEND;
                end
                SEND: if (!m_master_bsy) begin
                    exec_d  = 1'b1;
                    state_d = WAIT_ACK;
                end
                WAIT_ACK: if (m_dvalid) begin
                    hold_d  = 1'b0;
                    ret_d   = '0;
                    state_d = WAIT_RET;
                end
                WAIT_RET: begin
                    ret_d = ret_q + RET_TO_LEN'(1);
                    if (write_en_internal) begin
                        rx_d    = data_out_parellel;
                        state_d = CHECK;
                    end else if (&ret_q) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
                CHECK: begin
`ifdef RING_CHECK_EN
                    if (rx_q != tx_q + DATA_WIDTH'(1)) mismatch_d = 1'b1;
`endif
                    round_d = round_inc;
                    tx_d    = rx_q;
                    if (n_rounds != 8'd0 && round_inc == n_rounds) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ARM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            round_q    <= '0;
            ret_q      <= '0;
            hold_q     <= 1'b0;
            exec_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            round_q    <= round_d;
            ret_q      <= ret_d;
            hold_q     <= hold_d;
            exec_q     <= exec_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_value  = tx_q;
    assign rx_value  = rx_q;
    assign round_cnt = round_q;
    assign running   = (state_q != IDLE);
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign timeout   = timeout_q;
endmodule

// File: doc/ring_source_module.md
# ring_source_module

- Initiator end of the display ring.
- Writes a seed byte over the serial bus to the display slave (bus ID 0).
- Receives the display's incremented write-back through its own slave port (bus ID 2).
- Checks each returned value, forwards it as the next transmit value, and counts rounds until a programmed limit, a timeout or a stop.

## Interface
Parameters:
- DATA_WIDTH, 8, payload width
- ADDRS_WIDTH, 15, bus address width
- TIMEOUT_LEN, 6, master bus timeout width (bits)
- BIT_LENGTH, 4, master bit-length port width
- SELF_ID, 3'd2, slave ID of this block
- DEST_ADDR, {3'd0,12'b0}, display slave address
- RET_TO_LEN, 8, return-timeout counter width (2^RET_TO_LEN clocks)

Ports:
- clk  in  1  system clock; all logic on posedge
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- b_grant  in  1  arbiter grant to master
- arbiter_cmd_in  in  1  arbiter command to slave
- bus_util  inout  1  bus-utilising line
- data_bus_serial  inout  1  serial data line
- b_RW  inout  1  bus read/write line
- start  in  1  one-cycle pulse, begins a run
- stop  in  1  level, aborts a run
- seed  in  8  first transmit value
- n_rounds  in  8  rounds per run; 0 = continuous
- b_request  out  1  master bus request
- m_master_bsy  out  1  master busy
- busy_out  out  1  slave busy
- mst_state  out  4  master state
- slv_state  out  4  slave state
- tx_value  out  8  value last sent
- rx_value  out  8  value last received
- round_cnt  out  8  completed rounds
- running  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- mismatch  out  1  sticky: return != tx_value+1
- timeout  out  1  sticky: no return within window

## Operation
- Instantiates the team master (m_RW=1, m_address=DEST_ADDR, m_din=tx_value) and slave (SELF_ID, data_in_parellel=rx_value).
- slave module_dv is registered: (req_int_data | write_en_internal) delayed one clock.
- FSM states: IDLE, ARM, SEND, WAIT_ACK, WAIT_RET, CHECK.
- IDLE: m_hold=0, m_execute=0.
  - On start: tx_value<=seed, round_cnt<=0, clear mismatch and timeout, go to ARM.
- ARM: m_hold<=1, go to SEND.
- SEND: m_hold=1.
  - If ~m_master_bsy: m_execute<=1 for one cycle, go to WAIT_ACK.
  - Otherwise stay.
- WAIT_ACK: m_hold=1.
  - On m_dvalid: m_hold<=0, ret_timer<=0, go to WAIT_RET.
- WAIT_RET: ret_timer increments.
  - On write_en_internal: rx_value<=data_out_parellel, go to CHECK.
  - Else if ret_timer is all ones: timeout<=1, done pulse, go to IDLE.
- CHECK:
  - If rx_value != tx_value+1 (mod 256): mismatch<=1.
  - round_cnt<=round_cnt+1 (wraps 255->0); tx_value<=rx_value.
  - If n_rounds!=0 and round_cnt+1==n_rounds: done pulse, go to IDLE.
  - Otherwise go to ARM.
- stop sampled high in any non-IDLE state: go to IDLE next clock, m_hold<=0, m_execute<=0, done pulse; counters and flags kept.
- Boundaries:
  - start while running is ignored.
  - write_en_internal and timer expiry in the same cycle: the data wins.
  - stop and write_en_internal in the same cycle: stop wins, rx_value is not updated.
  - Writes received in IDLE update rx_value only.

## Timing
- Reset (rstn low at posedge): all outputs driven by this block are 0, FSM in IDLE, ret_timer 0.
  - Reset mid-operation drops m_hold at the next edge.
- start to m_hold high: 2 clocks (IDLE->ARM, ARM asserts).
- m_execute: exactly one clock, issued the clock after SEND samples ~m_master_bsy.
- Return timeout: 2^RET_TO_LEN clocks after m_dvalid.
- CHECK lasts one clock; done is registered and asserted for one clock.
- running = (state != IDLE).

## Configuration
- RING_CHECK_EN defined: comparator and mismatch flag are built as described.
- Undefined: mismatch is tied 0, any returned value is accepted and forwarded, and no comparator logic is synthesised.

## Test plan
- Reset with start held high: all outputs 0, FSM IDLE, no b_request.
- seed=8'h05, n_rounds=1, bench display model returns 8'h06: tx_value 05, one m_execute pulse, rx_value 06, round_cnt 1, done pulse, mismatch 0.
- seed=8'hFE, n_rounds=3, model returns +1: rx sequence FF, 00, 01; round_cnt 3; mismatch 0 (wrap accepted).
- Model returns 8'h09 for seed 8'h05: mismatch=1 with RING_CHECK_EN defined, mismatch=0 without it.
- No return after ack: timeout=1 exactly 256 clocks after m_dvalid, done pulse, FSM IDLE.
- stop asserted in WAIT_ACK: m_hold low next clock, done pulse; a following start restarts cleanly with round_cnt 0.
